// File: rtl/alu_muldiv_seq_if.sv
// rtl/alu_muldiv_seq_if.sv - request/response handshake and shared ALU port bundle for the mul/div sequencer
interface alu_muldiv_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        busy;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_cf;

    // Requester and ALU side: issues requests, consumes responses, computes ALU results
    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready, alu_result, alu_cf,
        input  req_ready, resp_valid, resp_data, busy, alu_a, alu_b, alu_ctrl
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready, alu_result, alu_cf,
        output req_ready, resp_valid, resp_data, busy, alu_a, alu_b, alu_ctrl
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - 32-iteration unsigned MUL/MULHU/DIVU/REMU sequencer driving a shared add/sub ALU
module alu_muldiv_seq (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_muldiv_seq_if.slave        bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    state_t      state;
    state_t      state_next;
    logic [1:0]  op;
    logic [31:0] d;
    // hi doubles as the remainder and lo as the quotient for divides
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  cnt;

    logic        accept;
    logic        is_div_req;
    logic        div_by_zero;
    logic [31:0] shifted;
    logic        sub_ok;

    assign accept      = bus.req_valid && (state == S_IDLE);
    assign is_div_req  = bus.req_op[1];
    assign div_by_zero = is_div_req && (bus.req_b == 32'd0);
    // Remainder shifted left with the next dividend bit brought in from the quotient register
    assign shifted     = {hi[30:0], lo[31]};
    // Subtraction is kept when the 33-bit partial remainder is at least D
    assign sub_ok      = hi[31] | bus.alu_cf;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake/ALU outputs
    always_comb begin
        state_next     = state;
        bus.req_ready  = 1'b0;
        bus.busy       = 1'b1;
        bus.resp_valid = 1'b0;
        bus.resp_data  = 32'd0;
        bus.alu_a      = 32'd0;
        bus.alu_b      = 32'd0;
        bus.alu_ctrl   = ALU_ADD;
        case (state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.req_valid) begin
                    state_next = div_by_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (op[1]) begin
                    bus.alu_ctrl = ALU_SUB;
                    bus.alu_a    = shifted;
                    bus.alu_b    = d;
                end else begin
                    bus.alu_ctrl = ALU_ADD;
                    bus.alu_a    = hi;
                    bus.alu_b    = lo[0] ? d : 32'd0;
                end
                if (cnt == 5'd31) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                bus.resp_valid = 1'b1;
                case (op)
                    OP_MUL:   bus.resp_data = lo;
                    OP_MULHU: bus.resp_data = hi;
                    OP_DIVU:  bus.resp_data = lo;
                    OP_REMU:  bus.resp_data = hi;
                    default:  bus.resp_data = 32'd0;
                endcase
                if (bus.resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand latch on accept and one shift-add / restoring-divide step per CALC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op  <= 2'd0;
            d   <= 32'd0;
            hi  <= 32'd0;
            lo  <= 32'd0;
            cnt <= 5'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op  <= bus.req_op;
                        d   <= bus.req_b;
                        cnt <= 5'd0;
                        if (div_by_zero) begin
                            hi <= bus.req_a;
                            lo <= 32'hFFFF_FFFF;
                        end else begin
                            hi <= 32'd0;
                            lo <= bus.req_a;
                        end
                    end
                end
                S_CALC: begin
                    cnt <= cnt + 5'd1;
                    if (op[1]) begin
                        if (sub_ok) begin
                            hi <= bus.alu_result;
                            lo <= {lo[30:0], 1'b1};
                        end else begin
                            hi <= shifted;
                            lo <= {lo[30:0], 1'b0};
                        end
                    end else begin
                        hi <= {bus.alu_cf, bus.alu_result[31:1]};
                        lo <= {bus.alu_result[0], lo[31:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - directed vector bench for the mul/div sequencer with a behavioural add/sub ALU
module tb_alu_muldiv_seq;
    logic clk;
    logic rst_n;

    alu_muldiv_seq_if bus_if ();

    alu_muldiv_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: add on 000, subtract on 001 with carry meaning no borrow
    logic [32:0] alu_sum;
    always_comb begin
        if (bus_if.alu_ctrl == 3'b001) begin
            alu_sum = {1'b0, bus_if.alu_a} + {1'b0, ~bus_if.alu_b} + 33'd1;
        end else begin
            alu_sum = {1'b0, bus_if.alu_a} + {1'b0, bus_if.alu_b};
        end
    end
    assign bus_if.alu_result = alu_sum[31:0];
    assign bus_if.alu_cf     = alu_sum[32];

    int n_checks;
    int n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"},  {31'd0, bus_if.req_ready},  32'd1);
        chk({tag, "_busy"},       {31'd0, bus_if.busy},       32'd0);
        chk({tag, "_resp_valid"}, {31'd0, bus_if.resp_valid}, 32'd0);
        chk({tag, "_resp_data"},  bus_if.resp_data,           32'd0);
        chk({tag, "_alu_a"},      bus_if.alu_a,               32'd0);
        chk({tag, "_alu_b"},      bus_if.alu_b,               32'd0);
        chk({tag, "_alu_ctrl"},   {29'd0, bus_if.alu_ctrl},   32'd0);
    endtask

    // Issue one request, wait for the response, take it; lat counts cycles from accept to resp_valid
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] data, output int lat);
        int guard;
        data = 32'd0;
        lat  = 0;
        @(negedge clk);
        guard = 0;
        while (!bus_if.req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready_before_issue", {31'd0, bus_if.req_ready}, 32'd1);
        bus_if.req_valid = 1'b1;
        bus_if.req_op    = op;
        bus_if.req_a     = a;
        bus_if.req_b     = b;
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        lat   = 1;
        guard = 0;
        while (!bus_if.resp_valid && guard < 100) begin
            @(posedge clk);
            #1;
            lat++;
            guard++;
        end
        chk("resp_valid_timeout", {31'd0, bus_if.resp_valid}, 32'd1);
        data = bus_if.resp_data;
        @(negedge clk);
        bus_if.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.resp_ready = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] data;
        logic [31:0] a_pat;
        int          lat;
        int          guard;
        int          seen;

        n_checks = 0;
        n_fail   = 0;
        bus_if.req_valid  = 1'b0;
        bus_if.req_op     = 2'b00;
        bus_if.req_a      = 32'd0;
        bus_if.req_b      = 32'd0;
        bus_if.resp_ready = 1'b0;

        vecs[0]  = '{"mul_ffff",    2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33};
        vecs[1]  = '{"mulhu_ffff",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[2]  = '{"divu_100_7",  2'b10, 32'd100,       32'd7,         32'd14,        33};
        vecs[3]  = '{"remu_100_7",  2'b11, 32'd100,       32'd7,         32'd2,         33};
        vecs[4]  = '{"divu_big",    2'b10, 32'h8000_0001, 32'hFFFF_FFFF, 32'd0,         33};
        vecs[5]  = '{"remu_big",    2'b11, 32'h8000_0001, 32'hFFFF_FFFF, 32'h8000_0001, 33};
        vecs[6]  = '{"divu_zero",   2'b10, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 1};
        vecs[7]  = '{"remu_zero",   2'b11, 32'h0000_1234, 32'd0,         32'h0000_1234, 1};
        vecs[8]  = '{"mul_2p16",    2'b00, 32'h0001_0000, 32'h0001_0000, 32'd0,         33};
        vecs[9]  = '{"mulhu_2p16",  2'b01, 32'h0001_0000, 32'h0001_0000, 32'd1,         33};
        vecs[10] = '{"divu_by1",    2'b10, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33};
        vecs[11] = '{"remu_by16",   2'b11, 32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 33};

        rst_n = 1'b0;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, data, lat);
            chk({vecs[i].name, "_data"}, data, vecs[i].exp);
            chk({vecs[i].name, "_latency"}, lat, vecs[i].lat);
        end

        // Asynchronous reset at step 10 of MUL 7x6
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_op    = 2'b00;
        bus_if.req_a     = 32'd7;
        bus_if.req_b     = 32'd6;
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("mid_calc_busy", {31'd0, bus_if.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus_if.resp_valid) seen++;
        end
        chk("no_resp_after_reset", seen, 32'd0);
        chk("req_ready_after_reset", {31'd0, bus_if.req_ready}, 32'd1);
        run_op(2'b00, 32'd3, 32'd4, data, lat);
        chk("mul_3x4_after_reset", data, 32'd12);

        // Back-pressure with req_valid held high throughout
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_op    = 2'b00;
        bus_if.req_a     = 32'd5;
        bus_if.req_b     = 32'd9;
        @(posedge clk);
        #1;
        guard = 0;
        while (!bus_if.resp_valid && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("bp_resp_valid", {31'd0, bus_if.resp_valid}, 32'd1);
        for (int k = 0; k < 20; k++) begin
            chk("bp_resp_data_stable", bus_if.resp_data, 32'd45);
            chk("bp_req_ready_low", {31'd0, bus_if.req_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        chk("bp_still_valid", {31'd0, bus_if.resp_valid}, 32'd1);
        @(negedge clk);
        bus_if.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.resp_ready = 1'b0;
        chk("bp_release_idle", {31'd0, bus_if.req_ready}, 32'd1);
        chk("bp_release_no_valid", {31'd0, bus_if.resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        chk("bp_next_accept_busy", {31'd0, bus_if.busy}, 32'd1);
        guard = 0;
        while (!bus_if.resp_valid && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("bp_second_resp", bus_if.resp_data, 32'd45);
        @(negedge clk);
        bus_if.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.resp_ready = 1'b0;

        // ALU port behaviour for MUL with b=1
        a_pat = 32'hA5A5_0F0F;
        @(negedge clk);
        chk("idle_alu_a", bus_if.alu_a, 32'd0);
        chk("idle_alu_b", bus_if.alu_b, 32'd0);
        bus_if.req_valid = 1'b1;
        bus_if.req_op    = 2'b00;
        bus_if.req_a     = a_pat;
        bus_if.req_b     = 32'd1;
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            chk("calc_alu_ctrl", {29'd0, bus_if.alu_ctrl}, 32'd0);
            chk("calc_alu_b", bus_if.alu_b, {31'd0, a_pat[k]});
            @(posedge clk);
            #1;
        end
        chk("alu_chk_resp_valid", {31'd0, bus_if.resp_valid}, 32'd1);
        chk("alu_chk_result", bus_if.resp_data, a_pat);
        chk("done_alu_a", bus_if.alu_a, 32'd0);
        chk("done_alu_b", bus_if.alu_b, 32'd0);
        chk("done_alu_ctrl", {29'd0, bus_if.alu_ctrl}, 32'd0);
        @(negedge clk);
        bus_if.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.resp_ready = 1'b0;
        chk("final_idle", {31'd0, bus_if.req_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
